spi_shift_engine: RTL and testbench

SPI datapath driven by the SPI edge-sequencing FSM (inputs `sck_step`, `reg_rst`, `adc_conv`; outputs `edg_done`, `amp_adc`). Each FSM step toggles SCK. The block counts edges, shifts the programmable preamp gain word out on MOSI, and captures the dual-channel ADC frame from MISO. It presents the two 14-bit samples to the acquisition logic with a one-cycle valid strobe.

---
 rtl/spi_pkg.sv | 34 +++
 rtl/spi_edge_counter.sv | 57 +++++
 rtl/spi_shift_engine.sv | 151 +++++++++++++++
 tb/tb_spi_shift_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared constants, mode encoding and edge-target helper for the SPI shift engine.
`default_nettype none

package spi_pkg;

  localparam int AMP_BITS  = 8;
  localparam int ADC_FRAME = 34;
  localparam int SAMPLE_W  = 14;
  localparam int CNT_W     = 7;
  localparam int RISE_W    = CNT_W - 1;

  localparam logic [CNT_W-1:0] AMP_EDGES = CNT_W'(2 * AMP_BITS);
  localparam logic [CNT_W-1:0] ADC_EDGES = CNT_W'(2 * ADC_FRAME);

  localparam logic [AMP_BITS-1:0] GAIN_RST = 8'h11;

  // Rising-edge numbers (1-based) that carry each channel's sample, MSB first.
  localparam logic [RISE_W-1:0] RISE_A_FIRST = RISE_W'(3);
  localparam logic [RISE_W-1:0] RISE_A_LAST  = RISE_W'(3 + SAMPLE_W - 1);
  localparam logic [RISE_W-1:0] RISE_B_FIRST = RISE_W'(19);
  localparam logic [RISE_W-1:0] RISE_B_LAST  = RISE_W'(19 + SAMPLE_W - 1);

  typedef enum logic {
    MODE_AMP = 1'b0,
    MODE_ADC = 1'b1
  } mode_e;

  function automatic logic [CNT_W-1:0] edge_target(input mode_e mode);
    return (mode == MODE_ADC) ? ADC_EDGES : AMP_EDGES;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_edge_counter.sv
// spi_edge_counter: saturating SCK edge counter, SCK toggle flop and frame-done flag.
`default_nettype none

module spi_edge_counter
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] target_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             adv_o,
  output logic             sck_o,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             done_q, done_d;
  logic             adv;

  always_comb begin
    // Clear has priority, so a step landing on the clear cycle is dropped.
    adv    = step_i & ~clear_i & (cnt_q < target_i);
    cnt_d  = cnt_q;
    sck_d  = sck_q;
    if (clear_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (adv) begin
      cnt_d = cnt_q + 1'b1;
      sck_d = ~sck_q;
    end
    done_d = ~clear_i & (cnt_d == target_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sck_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sck_q  <= sck_d;
      done_q <= done_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign adv_o  = adv;
  assign sck_o  = sck_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: preamp gain shift-out and dual-channel ADC frame capture on a stepped SPI clock.
`default_nettype none

module spi_shift_engine
  import spi_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                sck_step,
  input  logic                reg_rst,
  input  logic                adc_conv,
  input  logic [3:0]          gain_a,
  input  logic [3:0]          gain_b,
  input  logic                gain_load,
  input  logic                miso,
  output logic                spi_sck,
  output logic                spi_mosi,
  output logic                amp_cs_n,
  output logic                ad_conv,
  output logic                edg_done,
  output logic                amp_adc,
  output logic [SAMPLE_W-1:0] sample_a,
  output logic [SAMPLE_W-1:0] sample_b,
  output logic                sample_valid
);

  mode_e               mode_q, mode_d;
  logic                cs_n_q, cs_n_d;
  logic                ad_conv_q, ad_conv_d;
  logic [AMP_BITS-1:0] gain_q, gain_d;
  logic                pend_q, pend_d;
  logic                first_q, first_d;
  logic [AMP_BITS-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] shad_a_q, shad_a_d;
  logic [SAMPLE_W-1:0] shad_b_q, shad_b_d;
  logic [SAMPLE_W-1:0] samp_a_q, samp_a_d;
  logic [SAMPLE_W-1:0] samp_b_q, samp_b_d;
  logic                valid_q, valid_d;

  logic [CNT_W-1:0]    edge_cnt;
  logic                adv;
  logic [RISE_W-1:0]   rise_idx;

  spi_edge_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .step_i   (sck_step),
    .clear_i  (reg_rst),
    .target_i (edge_target(mode_q)),
    .cnt_o    (edge_cnt),
    .adv_o    (adv),
    .sck_o    (spi_sck),
    .done_o   (edg_done)
  );

  // An accepted step from an even count produces rising edge number cnt/2 + 1.
  assign rise_idx = edge_cnt[CNT_W-1:1] + RISE_W'(1);

  always_comb begin
    mode_d    = mode_q;
    cs_n_d    = (mode_q != MODE_AMP);
    ad_conv_d = adc_conv;
    gain_d    = gain_q;
    pend_d    = pend_q;
    first_d   = first_q;
    shreg_d   = shreg_q;
    shad_a_d  = shad_a_q;
    shad_b_d  = shad_b_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    valid_d   = 1'b0;

    if (mode_q == MODE_AMP) begin
      if (adv && edge_cnt[0]) begin
        shreg_d = {shreg_q[AMP_BITS-2:0], 1'b0};
      end else if (edge_cnt == '0) begin
        shreg_d = gain_q;
      end
    end else if (adv && !edge_cnt[0]) begin
      if (rise_idx >= RISE_A_FIRST && rise_idx <= RISE_A_LAST) begin
        shad_a_d = {shad_a_q[SAMPLE_W-2:0], miso};
      end
      if (rise_idx >= RISE_B_FIRST && rise_idx <= RISE_B_LAST) begin
        shad_b_d = {shad_b_q[SAMPLE_W-2:0], miso};
      end
    end

    // Only a completed frame changes mode or publishes samples; an abort just clears the counter.
    if (reg_rst && edg_done) begin
      if (mode_q == MODE_AMP) begin
        mode_d  = MODE_ADC;
        first_d = 1'b1;
      end else begin
        samp_a_d = shad_a_q;
        samp_b_d = shad_b_q;
        valid_d  = ~first_q;
        first_d  = 1'b0;
        if (pend_q) begin
          mode_d = MODE_AMP;
          pend_d = 1'b0;
        end
      end
    end

    if (gain_load && mode_q == MODE_ADC) begin
      gain_d = {gain_b, gain_a};
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= MODE_AMP;
      cs_n_q    <= 1'b1;
      ad_conv_q <= 1'b0;
      gain_q    <= GAIN_RST;
      pend_q    <= 1'b0;
      first_q   <= 1'b0;
      shreg_q   <= '0;
      shad_a_q  <= '0;
      shad_b_q  <= '0;
      samp_a_q  <= '0;
      samp_b_q  <= '0;
      valid_q   <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      cs_n_q    <= cs_n_d;
      ad_conv_q <= ad_conv_d;
      gain_q    <= gain_d;
      pend_q    <= pend_d;
      first_q   <= first_d;
      shreg_q   <= shreg_d;
      shad_a_q  <= shad_a_d;
      shad_b_q  <= shad_b_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      valid_q   <= valid_d;
    end
  end

  assign spi_mosi     = (mode_q == MODE_AMP) & shreg_q[AMP_BITS-1];
  assign amp_cs_n     = cs_n_q;
  assign ad_conv      = ad_conv_q;
  assign amp_adc      = mode_q;
  assign sample_a     = samp_a_q;
  assign sample_b     = samp_b_q;
  assign sample_valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_shift_engine.sv
// tb_spi_shift_engine: directed self-checking bench for spi_shift_engine.
`default_nettype none

module tb_spi_shift_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck_step = 1'b0;
  logic        reg_rst = 1'b0;
  logic        adc_conv = 1'b0;
  logic [3:0]  gain_a = 4'h0;
  logic [3:0]  gain_b = 4'h0;
  logic        gain_load = 1'b0;
  logic        miso = 1'b0;
  logic        spi_sck, spi_mosi, amp_cs_n, ad_conv, edg_done, amp_adc, sample_valid;
  logic [13:0] sample_a, sample_b;

  int n_chk  = 0;
  int n_fail = 0;

  spi_shift_engine dut (
    .clk          (clk),
    .rst          (rst),
    .sck_step     (sck_step),
    .reg_rst      (reg_rst),
    .adc_conv     (adc_conv),
    .gain_a       (gain_a),
    .gain_b       (gain_b),
    .gain_load    (gain_load),
    .miso         (miso),
    .spi_sck      (spi_sck),
    .spi_mosi     (spi_mosi),
    .amp_cs_n     (amp_cs_n),
    .ad_conv      (ad_conv),
    .edg_done     (edg_done),
    .amp_adc      (amp_adc),
    .sample_a     (sample_a),
    .sample_b     (sample_b),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic bit_i);
    @(negedge clk);
    miso     = bit_i;
    sck_step = 1'b1;
    @(negedge clk);
    sck_step = 1'b0;
  endtask

  task automatic pulse_reg_rst();
    @(negedge clk);
    reg_rst = 1'b1;
    @(negedge clk);
    reg_rst = 1'b0;
  endtask

  task automatic load_gain(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    gain_a    = a;
    gain_b    = b;
    gain_load = 1'b1;
    @(negedge clk);
    gain_load = 1'b0;
  endtask

  // Expected MISO bit for edge e: rising edges 3..16 carry A, 19..32 carry B, rest are filler ones.
  function automatic logic adc_bit(input int e, input logic [13:0] a, input logic [13:0] b);
    int r;
    r = (e + 1) / 2;
    if (r >= 3 && r <= 16) return a[16 - r];
    if (r >= 19 && r <= 32) return b[32 - r];
    return 1'b1;
  endfunction

  task automatic adc_steps(input int from_e, input int to_e, input logic [13:0] a, input logic [13:0] b);
    for (int e = from_e; e <= to_e; e++) step(adc_bit(e, a, b));
  endtask

  task automatic amp_frame(input string tag, input logic [7:0] exp_word);
    logic [7:0] got;
    got = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      step(1'b0);
      if (k % 2 == 1) got[7 - (k - 1) / 2] = spi_mosi;
      if (k == 15) check_val({tag, "_done_early"}, {31'd0, edg_done}, 32'd0);
    end
    check_val({tag, "_mosi"}, {24'd0, got}, {24'd0, exp_word});
    check_val({tag, "_done"}, {31'd0, edg_done}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_val("rst_sck",   {31'd0, spi_sck},      32'd0);
    check_val("rst_mosi",  {31'd0, spi_mosi},     32'd0);
    check_val("rst_cs_n",  {31'd0, amp_cs_n},     32'd1);
    check_val("rst_adconv",{31'd0, ad_conv},      32'd0);
    check_val("rst_done",  {31'd0, edg_done},     32'd0);
    check_val("rst_mode",  {31'd0, amp_adc},      32'd0);
    check_val("rst_samp_a",{18'd0, sample_a},     32'd0);
    check_val("rst_valid", {31'd0, sample_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("amp_cs_low", {31'd0, amp_cs_n}, 32'd0);

    // gain_load in amp mode is ignored: the default word must still go out.
    load_gain(4'hF, 4'hF);
    amp_frame("amp0", 8'h11);

    for (int k = 0; k < 4; k++) step(1'b0);
    check_val("sat_sck", {31'd0, spi_sck}, 32'd0);
    check_val("sat_cnt", {25'd0, dut.edge_cnt}, 32'd16);
    check_val("sat_done", {31'd0, edg_done}, 32'd1);

    pulse_reg_rst();
    check_val("amp_end_mode", {31'd0, amp_adc},  32'd1);
    check_val("amp_end_done", {31'd0, edg_done}, 32'd0);
    check_val("amp_end_cs0",  {31'd0, amp_cs_n}, 32'd0);
    @(negedge clk);
    check_val("amp_end_cs1",  {31'd0, amp_cs_n}, 32'd1);

    @(negedge clk);
    adc_conv = 1'b1;
    @(negedge clk);
    adc_conv = 1'b0;
    check_val("adconv_hi", {31'd0, ad_conv}, 32'd1);
    @(negedge clk);
    check_val("adconv_lo", {31'd0, ad_conv}, 32'd0);

    adc_steps(1, 68, 14'h3FFF, 14'h0000);
    check_val("adc1_done", {31'd0, edg_done}, 32'd1);
    check_val("adc1_mosi", {31'd0, spi_mosi}, 32'd0);
    pulse_reg_rst();
    check_val("adc1_novalid", {31'd0, sample_valid}, 32'd0);
    check_val("adc1_mode",    {31'd0, amp_adc},      32'd1);

    adc_steps(1, 68, 14'h1ABC, 14'h0123);
    pulse_reg_rst();
    check_val("adc2_valid", {31'd0, sample_valid}, 32'd1);
    check_val("adc2_a",     {18'd0, sample_a},     32'h1ABC);
    check_val("adc2_b",     {18'd0, sample_b},     32'h0123);
    @(negedge clk);
    check_val("adc2_valid_off", {31'd0, sample_valid}, 32'd0);

    adc_steps(1, 30, 14'h0F0F, 14'h00FF);
    pulse_reg_rst();
    check_val("abort_valid", {31'd0, sample_valid}, 32'd0);
    check_val("abort_mode",  {31'd0, amp_adc},      32'd1);
    check_val("abort_cnt",   {25'd0, dut.edge_cnt}, 32'd0);
    check_val("abort_sck",   {31'd0, spi_sck},      32'd0);
    check_val("abort_a",     {18'd0, sample_a},     32'h1ABC);

    adc_steps(1, 20, 14'h2AAA, 14'h1555);
    load_gain(4'h3, 4'h5);
    adc_steps(21, 68, 14'h2AAA, 14'h1555);
    pulse_reg_rst();
    check_val("reprog_valid", {31'd0, sample_valid}, 32'd1);
    check_val("reprog_a",     {18'd0, sample_a},     32'h2AAA);
    check_val("reprog_b",     {18'd0, sample_b},     32'h1555);
    check_val("reprog_mode",  {31'd0, amp_adc},      32'd0);
    amp_frame("amp53", 8'h53);
    pulse_reg_rst();
    check_val("amp53_mode", {31'd0, amp_adc}, 32'd1);

    // Reset lands on the 40th step of an ADC frame; that step must not toggle SCK.
    adc_steps(1, 39, 14'h0000, 14'h0000);
    @(negedge clk);
    sck_step = 1'b1;
    rst      = 1'b1;
    @(negedge clk);
    sck_step = 1'b0;
    check_val("mid_rst_sck",   {31'd0, spi_sck},      32'd0);
    check_val("mid_rst_cnt",   {25'd0, dut.edge_cnt}, 32'd0);
    check_val("mid_rst_mode",  {31'd0, amp_adc},      32'd0);
    check_val("mid_rst_cs_n",  {31'd0, amp_cs_n},     32'd1);
    check_val("mid_rst_a",     {18'd0, sample_a},     32'd0);
    check_val("mid_rst_valid", {31'd0, sample_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    amp_frame("amp_post_rst", 8'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
